cell_bist: RTL and testbench

CELL_BIST -- requirements
Module: cell_bist

---
 rtl/cell_bist_if.sv | 13 +
 rtl/cell_bist.sv | 66 ++++++
 tb/tb_cell_bist.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cell_bist_if.sv
// cell_bist_if: run control, cell-under-test pins and result bus of the BIST engine
interface cell_bist_if;
  logic        start;
  logic [15:0] golden;
  logic        cut_y;
  logic [3:0]  cut_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  modport master (output start, golden, cut_y, input cut_in, busy, done, pass, sig);
  modport slave  (input start, golden, cut_y, output cut_in, busy, done, pass, sig);
endinterface

// File: rtl/cell_bist.sv
// cell_bist: exhaustive 16-pattern BIST of a 4-input cell with CRC-16 signature compaction
module cell_bist #(
  parameter int          SETTLE   = 1,
  parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
  input logic       clk,
  input logic       clrb,
  cell_bist_if.slave b
);
  typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, COMPARE, DONE} state_t;
  state_t      state;
  logic [3:0]  pat, idx, cnt, cut_in, nxt;
  logic [15:0] sig;
  logic        pass, fb;
  // the LFSR never reaches zero, so the last pattern is forced to cover 4'b0000
  assign nxt = idx == 4'd14 ? 4'd0 : {pat[2:0], pat[3] ^ pat[2]};
  assign fb  = sig[15] ^ b.cut_y;
  always_ff @(posedge clk or negedge clrb)
    if (!clrb) begin
      state  <= IDLE;
      pat    <= 4'b0001;
      idx    <= '0;
      cnt    <= '0;
      cut_in <= '0;
      sig    <= SIG_SEED;
      pass   <= 1'b0;
    end else
      case (state)
        IDLE: if (b.start) begin
          state  <= APPLY;
          pat    <= 4'b0001;
          cut_in <= 4'b0001;
          sig    <= SIG_SEED;
          idx    <= '0;
          cnt    <= '0;
          pass   <= 1'b0;
        end
        APPLY: begin
          state <= cnt == 4'(SETTLE - 1) ? SAMPLE : APPLY;
          cnt   <= cnt == 4'(SETTLE - 1) ? 4'd0 : cnt + 4'd1;
        end
        SAMPLE: begin
          sig <= {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
          if (idx == 4'd15) begin
            state  <= COMPARE;
            cut_in <= '0;
          end else begin
            state  <= APPLY;
            idx    <= idx + 4'd1;
            pat    <= nxt;
            cut_in <= nxt;
          end
        end
        COMPARE: begin
          pass  <= sig == b.golden;
          state <= DONE;
        end
        DONE:    state <= b.start ? DONE : IDLE;
        default: state <= IDLE;
      endcase
  assign b.cut_in = cut_in;
  assign b.sig    = sig;
  assign b.pass   = pass;
  assign b.busy   = state == APPLY || state == SAMPLE || state == COMPARE;
  assign b.done   = state == DONE;
endmodule

// File: tb/tb_cell_bist.sv
// tb_cell_bist: directed runs of cell_bist against an AOI22 cell, scoreboarded on DONE
module tb_cell_bist;
  logic clk = 1'b0, clrb = 1'b1, stuck1 = 1'b0;
  int   cyc = 0, vecs = 0, errs = 0, t0 = 0, t3 = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cell_bist_if b1 ();
  cell_bist_if b3 ();
  cell_bist #(.SETTLE(1)) u1 (.clk(clk), .clrb(clrb), .b(b1.slave));
  cell_bist #(.SETTLE(3)) u3 (.clk(clk), .clrb(clrb), .b(b3.slave));
  typedef struct {logic [15:0] sig; logic pass; int lat;} exp_t;
  exp_t q1[$], q3[$], e1, e3;
  logic d1p = 1'b0, d3p = 1'b0;
  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  function automatic logic aoi(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction
  function automatic logic [15:0] crc(input logic stk);
    logic [15:0] s = 16'hFFFF;
    logic y;
    for (int i = 0; i < 16; i++) begin
      y = stk ? 1'b0 : aoi(seq[i]);
      s = {s[14:0], 1'b0} ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction
  assign b1.cut_y = stuck1 ? 1'b0 : aoi(b1.cut_in);
  assign b3.cut_y = aoi(b3.cut_in);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b1.done && !d1p) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1_sig", 32'(b1.sig), 32'(e1.sig));
        chk("u1_pass", 32'(b1.pass), 32'(e1.pass));
        chk("u1_latency", cyc - t0, e1.lat);
      end
    end
    d1p = b1.done;
    if (b3.done && !d3p) begin
      if (q3.size() == 0) chk("u3_unexpected_done", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk("u3_sig", 32'(b3.sig), 32'(e3.sig));
        chk("u3_pass", 32'(b3.pass), 32'(e3.pass));
        chk("u3_latency", cyc - t3, e3.lat);
      end
    end
    d3p = b3.done;
  end
  task automatic run1(input logic [15:0] gold, input logic stk, input logic ep, input bit tog);
    int n = 0;
    stuck1 = stk;
    b1.golden = gold;
    q1.push_back('{crc(stk), ep, 33});
    @(negedge clk) b1.start = 1'b1;
    @(posedge clk) #1 t0 = cyc;
    b1.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("u1_cut_in_seq", 32'(b1.cut_in), 32'(seq[k / 2]));
      chk("u1_busy_run", 32'(b1.busy), 1);
      if (tog) begin
        b1.start  = k[0];
        b1.golden = k < 28 ? ~gold : gold;
      end
    end
    b1.start = 1'b0;
    do begin @(negedge clk); n++; end while (!b1.done && n < 4);
    chk("u1_done_seen", 32'(b1.done), 1);
    chk("u1_busy_done", 32'(b1.busy), 0);
    chk("u1_cut_in_done", 32'(b1.cut_in), 0);
    @(negedge clk);
    chk("u1_idle_after_drop", 32'(b1.done), 0);
    chk("u1_sig_kept", 32'(b1.sig), 32'(crc(stk)));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    b1.start = 1'b0; b1.golden = '0;
    b3.start = 1'b0; b3.golden = '0;
    #1 clrb = 1'b0;
    #2;
    chk("rst_cut_in", 32'(b1.cut_in), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_pass", 32'(b1.pass), 0);
    chk("rst_sig", 32'(b1.sig), 32'hFFFF);
    chk("rst_sig3", 32'(b3.sig), 32'hFFFF);
    repeat (2) @(negedge clk);
    clrb = 1'b1;
    run1(crc(1'b0), 1'b0, 1'b1, 1'b0);
    run1(crc(1'b0) ^ 16'h0001, 1'b0, 1'b0, 1'b0);
    run1(crc(1'b0), 1'b1, 1'b0, 1'b0);
    run1(crc(1'b0), 1'b0, 1'b1, 1'b1);
    // reset mid-run: no DONE may follow, outputs drop immediately
    @(negedge clk) b1.start = 1'b1;
    @(posedge clk) #1 b1.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 32'(b1.busy), 1);
    #2 clrb = 1'b0;
    #1;
    chk("abort_cut_in", 32'(b1.cut_in), 0);
    chk("abort_busy", 32'(b1.busy), 0);
    chk("abort_done", 32'(b1.done), 0);
    chk("abort_pass", 32'(b1.pass), 0);
    chk("abort_sig", 32'(b1.sig), 32'hFFFF);
    @(negedge clk) clrb = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(b1.done), 0);
    run1(crc(1'b0), 1'b0, 1'b1, 1'b0);
    // START held high: one run, DONE stays up
    b1.golden = crc(1'b0);
    q1.push_back('{crc(1'b0), 1'b1, 33});
    @(negedge clk) b1.start = 1'b1;
    @(posedge clk) #1 t0 = cyc;
    repeat (60) @(negedge clk);
    chk("hold_done", 32'(b1.done), 1);
    chk("hold_busy", 32'(b1.busy), 0);
    chk("hold_pass", 32'(b1.pass), 1);
    b1.start = 1'b0;
    @(negedge clk);
    chk("hold_release_done", 32'(b1.done), 0);
    chk("hold_release_cut_in", 32'(b1.cut_in), 0);
    // SETTLE=3 instance
    b3.golden = crc(1'b0);
    q3.push_back('{crc(1'b0), 1'b1, 65});
    @(negedge clk) b3.start = 1'b1;
    @(posedge clk) #1 t3 = cyc;
    b3.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("u3_cut_in_seq", 32'(b3.cut_in), 32'(seq[k / 4]));
    end
    for (int n = 0; n < 4 && !b3.done; n++) @(negedge clk);
    chk("u3_done_seen", 32'(b3.done), 1);
    repeat (4) @(negedge clk);
    chk("u1_queue_drained", q1.size(), 0);
    chk("u3_queue_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
